decade_carry_accumulator: RTL and testbench
===========================================

# decade_carry_accumulator

Downstream consumer of the 1-to-10 decade counter stage. Watches the counter's 4-bit output, detects each 10→1 wrap, and emits a one-cycle carry pulse. Accumulates wraps in a DIGITS-wide packed BCD counter and offers a snapshot handshake for a slower reader. An optional sequence checker flags illegal upstream values or steps.

## Interface
- DIGITS, 3: number of BCD digits in the wrap accumulator; legal range 1..8.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- q_in  in  4  upstream count value; legal values 1..10.
- q_valid  in  1  q_in is meaningful this cycle.
- carry  out  1  one-cycle pulse per detected wrap.
- bcd  out  4*DIGITS  live wrap count, packed BCD; digit 0 is in [3:0].
- overflow  out  1  sticky; set when bcd wraps from all-9s to all-0s.
- snap_req  in  1  request to capture bcd.
- snap_ack  in  1  reader has consumed snap_data.
- snap_valid  out  1  snap_data holds a captured value.
- snap_data  out  4*DIGITS  captured bcd.
- seq_err  out  1  sticky upstream-sequence error; present only with the checker macro.

## Operation
- History registers: prev_q (4b) and prev_vld (1b).
  - When q_valid=1: prev_q<=q_in and prev_vld<=1.
  - When q_valid=0: prev_vld<=0 and prev_q holds.
- Wrap condition, evaluated combinationally: q_valid && prev_vld && prev_q==10 && q_in==1.
- On a wrap:
  - carry<=1 for exactly one cycle.
  - bcd increments by 1 in BCD: a digit at 9 goes to 0 and carries into the next digit.
- A step to 1 from any value other than 10 is an upstream reset, not a wrap. No carry is produced.
- The first valid sample after reset, or after any q_valid=0 cycle, never produces a carry.
- Overflow: if every digit is 9 when a wrap occurs, bcd becomes all 0 and overflow<=1. overflow stays set until reset.
- Snapshot handshake:
  - A request is accepted when snap_req=1 and either snap_valid=0, or snap_valid=1 with snap_ack=1 in the same cycle.
  - On acceptance: snap_data<=bcd (the registered value before this edge's increment) and snap_valid<=1.
  - If snap_ack=1 and no request is accepted: snap_valid<=0.
  - snap_req while snap_valid=1 and snap_ack=0 is ignored. snap_data holds unchanged.
  - snap_ack while snap_valid=0 is ignored.
- Reset: carry, bcd, overflow, snap_valid, snap_data, seq_err, prev_q and prev_vld all go to 0.

## Timing
- Latency from the wrap sample edge to the carry pulse and bcd update is 1 cycle: both are registered on the same posedge.
- Back-to-back wraps are impossible from a legal upstream, because wraps are at least 10 valid cycles apart. No wrap queueing is required.
- snap_valid rises 1 cycle after an accepted snap_req.
- Snapshot and wrap on the same edge: snap_data gets the old bcd value, and bcd increments.
- With the checker, seq_err rises 1 cycle after the offending sample.
- Reset has priority over every other event, including a simultaneous wrap or snap_req.

## Configuration
- Macro DECADE_CARRY_ACC_SEQ_CHECK_EN.
- Defined: the seq_err port and checker logic are present. On a valid sample, seq_err<=1 if either:
  - q_in==0 or q_in>10, or
  - prev_vld and q_in is neither prev_q+1 (prev_q in 1..9) nor 1.
- Undefined: the seq_err port and checker logic are absent. Illegal q_in is never counted as a wrap and is otherwise ignored.

## Structure
- Shared package decade_pkg holds:
  - localparam DECADE_MAX=4'd10 and DECADE_MIN=4'd1.
  - typedef bcd_digit_t (logic [3:0]).
- One sub-module, bcd_digit:
  - Ports: clk, reset, inc_in, digit out, carry_out.
  - carry_out = inc_in && digit==9.
  - The top instantiates DIGITS copies in a generate chain, so overflow equals carry_out of the top digit.

## Test plan
- Reset, then 31 continuous valid samples 1..10,1..10,1..10,1 → exactly 3 single-cycle carry pulses, bcd=0x003, overflow=0.
- DIGITS=3, drive 1000 wraps → bcd=0x999 after 999 wraps; after the 1000th, bcd=0x000 and overflow=1 (sticky through a further 5 wraps).
- Sequence 1,2,3,4,5,1,2,…,10,1 → no carry on 5→1; one carry on 10→1; seq_err stays 0.
- With the checker: q_in=11 → seq_err=1 next cycle and stays set. Separately, after reset, 3 then 5 → seq_err=1. Also 10, q_valid=0, 1 → no carry.
- bcd=0x042, pulse snap_req → snap_valid=1 and snap_data=0x042 next cycle. Wrap to 0x043 with a second snap_req and no ack → data stays 0x042. snap_ack together with snap_req → snap_data=0x043 and snap_valid stays 1.
- bcd=0x017 with snap_valid=1, assert reset during a 10→1 wrap cycle → next cycle all outputs 0, no carry. The first valid q_in=1 after reset → no carry.

Source files
------------

// File: rtl/decade_pkg.sv
// decade_pkg: definitions shared by the decade carry accumulator and its digit cells.
//   DECADE_MAX / DECADE_MIN : upper and lower legal values of the upstream 1..10 counter.
//   bcd_digit_t             : one packed BCD digit.
package decade_pkg;

  localparam logic [3:0] DECADE_MAX = 4'd10;
  localparam logic [3:0] DECADE_MIN = 4'd1;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/decade_carry_accumulator_bcd_digit.sv
// bcd_digit: a single BCD counter digit for the ripple chain.
//   clk       in  : clock
//   reset     in  : synchronous, active-high reset; clears the digit
//   inc_in    in  : increment this digit on the next edge
//   digit     out : current digit value, 0..9
//   carry_out out : this increment rolls 9 -> 0; drives the next digit's inc_in
module bcd_digit
  import decade_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_in,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t r_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit <= '0;
    end else if (inc_in) begin
      r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit     = r_digit;
  assign carry_out = inc_in && (r_digit == 4'd9);

endmodule

// File: rtl/decade_carry_accumulator.sv
// decade_carry_accumulator: watches an upstream 1..10 decade counter, pulses
// carry once per 10 -> 1 wrap, counts wraps in a DIGITS-wide packed BCD
// counter, and offers a snapshot of that count to a slower reader.
//
// Handshake: snap_req is accepted when snap_valid is low, or when snap_valid
// is high and snap_ack is high in the same cycle. Acceptance loads snap_data
// with the pre-edge bcd and raises snap_valid; snap_ack without an accepted
// request drops snap_valid. A request while snap_valid=1 and snap_ack=0 is
// ignored and snap_data holds.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   q_in[3:0], q_valid    : upstream count and its qualifier
//   carry                 : one-cycle pulse per detected wrap
//   bcd[4*DIGITS-1:0]     : live wrap count, digit 0 in [3:0]
//   overflow              : sticky, set when bcd rolls all-9s -> all-0s
//   snap_req, snap_ack    : snapshot request / consume
//   snap_valid, snap_data : captured count and its qualifier
//   seq_err               : sticky upstream sequence error
//                           (only when DECADE_CARRY_ACC_SEQ_CHECK_EN is defined)
module decade_carry_accumulator
  import decade_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          q_in,
  input  logic                q_valid,
  output logic                carry,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  input  logic                snap_req,
  input  logic                snap_ack,
  output logic                snap_valid,
  output logic [4*DIGITS-1:0] snap_data
`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
  ,
  output logic                seq_err
`endif
);

  logic [3:0]          r_prev_q;
  logic                r_prev_vld;
  logic                r_carry;
  logic                r_overflow;
  logic                r_snap_valid;
  logic [4*DIGITS-1:0] r_snap_data;

  logic                w_wrap;
  logic                w_snap_accept;
  logic [DIGITS:0]     w_inc;
  logic [4*DIGITS-1:0] w_bcd;

  // A wrap needs two consecutive valid samples, 10 then 1; any other step to 1
  // is an upstream restart and must not count.
  assign w_wrap = q_valid && r_prev_vld && (r_prev_q == DECADE_MAX) && (q_in == DECADE_MIN);

  assign w_snap_accept = snap_req && (!r_snap_valid || snap_ack);

  // Ripple chain: each digit increments when every lower digit is rolling over.
  assign w_inc[0] = w_wrap;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .inc_in    (w_inc[gi]),
      .digit     (w_bcd[4*gi +: 4]),
      .carry_out (w_inc[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_q     <= '0;
      r_prev_vld   <= 1'b0;
      r_carry      <= 1'b0;
      r_overflow   <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_data  <= '0;
    end else begin
      if (q_valid) begin
        r_prev_q   <= q_in;
        r_prev_vld <= 1'b1;
      end else begin
        r_prev_vld <= 1'b0;
      end
      r_carry    <= w_wrap;
      // Top digit's carry_out is the whole counter rolling from all-9s.
      r_overflow <= r_overflow | w_inc[DIGITS];
      if (w_snap_accept) begin
        r_snap_data  <= w_bcd;
        r_snap_valid <= 1'b1;
      end else if (snap_ack) begin
        r_snap_valid <= 1'b0;
      end
    end
  end

  assign carry      = r_carry;
  assign bcd        = w_bcd;
  assign overflow   = r_overflow;
  assign snap_valid = r_snap_valid;
  assign snap_data  = r_snap_data;

`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
  logic r_seq_err;
  logic w_out_of_range;
  logic w_legal_step;

  assign w_out_of_range = (q_in == 4'd0) || (q_in > DECADE_MAX);
  // Legal successors: 1 from anything (wrap or restart), or prev+1 below 10.
  assign w_legal_step = (q_in == DECADE_MIN) ||
                        ((r_prev_q >= DECADE_MIN) && (r_prev_q < DECADE_MAX) &&
                         (q_in == r_prev_q + 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_err <= 1'b0;
    end else if (q_valid && (w_out_of_range || (r_prev_vld && !w_legal_step))) begin
      r_seq_err <= 1'b1;
    end
  end

  assign seq_err = r_seq_err;
`endif

endmodule

// File: tb/tb_decade_carry_accumulator.sv
// Bench for decade_carry_accumulator: directed scenarios plus randomized
// upstream/snapshot traffic, checked every cycle against a wrap-count model.
module tb_decade_carry_accumulator;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 1000;

  logic         clk;
  logic         reset;
  logic [3:0]   q_in;
  logic         q_valid;
  logic         carry;
  logic [W-1:0] bcd;
  logic         overflow;
  logic         snap_req;
  logic         snap_ack;
  logic         snap_valid;
  logic [W-1:0] snap_data;
`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
  logic         seq_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: wrap count as a plain integer, previous sample, snapshot.
  int     m_count;
  bit     m_prev_vld;
  int     m_prev_q;
  bit     m_carry;
  bit     m_sv;
  int     m_sd;
  bit     m_seq_err;
  int     g_q;

  decade_carry_accumulator #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .q_valid    (q_valid),
    .carry      (carry),
    .bcd        (bcd),
    .overflow   (overflow),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .snap_valid (snap_valid),
    .snap_data  (snap_data)
`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
    ,
    .seq_err    (seq_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input int q, input bit sr, input bit sa, input bit rst);
    bit wrap;
    if (rst) begin
      m_count = 0; m_prev_vld = 0; m_prev_q = 0; m_carry = 0;
      m_sv = 0; m_sd = 0; m_seq_err = 0;
      return;
    end
    wrap = v && m_prev_vld && (m_prev_q == 10) && (q == 1);
    if (sr && (!m_sv || sa)) begin
      m_sd = m_count % MOD;
      m_sv = 1;
    end else if (sa) begin
      m_sv = 0;
    end
    if (v) begin
      if (q < 1 || q > 10) m_seq_err = 1;
      else if (m_prev_vld && !(q == 1 || (m_prev_q >= 1 && m_prev_q <= 9 && q == m_prev_q + 1)))
        m_seq_err = 1;
    end
    m_carry = wrap;
    if (wrap) m_count++;
    if (v) begin
      m_prev_q = q;
      m_prev_vld = 1;
    end else begin
      m_prev_vld = 0;
    end
  endtask

  // Driver: one clock with the given inputs, then compare every output.
  task automatic cyc(input bit v, input int q, input bit sr, input bit sa, input bit rst);
    q_valid  = v;
    q_in     = 4'(q);
    snap_req = sr;
    snap_ack = sa;
    reset    = rst;
    model_step(v, q, sr, sa, rst);
    @(posedge clk);
    #1;
    check("carry", 32'(carry), 32'(m_carry));
    check("bcd", 32'(bcd), 32'(to_bcd(m_count % MOD)));
    check("overflow", 32'(overflow), 32'(m_count >= MOD));
    check("snap_valid", 32'(snap_valid), 32'(m_sv));
    check("snap_data", 32'(snap_data), 32'(to_bcd(m_sd)));
`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
    check("seq_err", 32'(seq_err), 32'(m_seq_err));
`endif
  endtask

  // Legal upstream sample continuing from g_q.
  task automatic nxt(input bit sr, input bit sa);
    cyc(1, g_q, sr, sa, 0);
    g_q = (g_q == 10) ? 1 : g_q + 1;
  endtask

  task automatic run(input int n, input bit rnd_snap);
    for (int i = 0; i < n; i++) begin
      if (rnd_snap) nxt(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      else nxt(0, 0);
    end
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
    g_q = 1;
  endtask

  initial begin
    q_valid = 0; q_in = 0; snap_req = 0; snap_ack = 0; reset = 1;
    m_count = 0; m_prev_vld = 0; m_prev_q = 0; m_carry = 0;
    m_sv = 0; m_sd = 0; m_seq_err = 0; g_q = 1;

    // Reset state
    do_reset();
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);

    // 31 continuous samples -> 3 wraps
    run(31, 0);
    check("three_wraps_bcd", 32'(bcd), 32'h003);
    check("three_wraps_ovf", 32'(overflow), 32'h0);

    // Upstream restart 5 -> 1 is not a wrap
    do_reset();
    for (int v = 1; v <= 5; v++) cyc(1, v, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("restart_no_carry", 32'(carry), 32'h0);
    for (int v = 2; v <= 10; v++) cyc(1, v, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("wrap_after_restart", 32'(carry), 32'h1);
    cyc(1, 2, 0, 0, 0);
    check("carry_one_cycle", 32'(carry), 32'h0);
    check("restart_bcd", 32'(bcd), 32'h001);

    // 10, invalid gap, 1 -> no carry
    cyc(1, 3, 0, 0, 0);
    cyc(1, 10, 0, 0, 0);
    cyc(0, 10, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("gap_no_carry", 32'(carry), 32'h0);

`ifdef DECADE_CARRY_ACC_SEQ_CHECK_EN
    do_reset();
    cyc(1, 11, 0, 0, 0);
    check("seq_err_11", 32'(seq_err), 32'h1);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    check("seq_err_sticky", 32'(seq_err), 32'h1);
    do_reset();
    cyc(1, 3, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    check("seq_err_skip", 32'(seq_err), 32'h1);
`endif

    // Snapshot handshake around bcd = 042
    do_reset();
    run(421, 0);
    check("snap_pre_bcd", 32'(bcd), 32'h042);
    nxt(1, 0);
    check("snap_first_valid", 32'(snap_valid), 32'h1);
    check("snap_first_data", 32'(snap_data), 32'h042);
    run(8, 0);
    nxt(1, 0);
    check("snap_hold_bcd", 32'(bcd), 32'h043);
    check("snap_hold_data", 32'(snap_data), 32'h042);
    nxt(1, 1);
    check("snap_reacq_data", 32'(snap_data), 32'h043);
    check("snap_reacq_valid", 32'(snap_valid), 32'h1);
    nxt(0, 1);
    check("snap_ack_drop", 32'(snap_valid), 32'h0);

    // Reset during a wrap with snapshot held at 017
    do_reset();
    run(171, 0);
    nxt(1, 0);
    run(8, 0);
    check("pre_rst_sv", 32'(snap_valid), 32'h1);
    check("pre_rst_bcd", 32'(bcd), 32'h017);
    cyc(1, 1, 1, 0, 1);
    g_q = 2;
    check("rst_wrap_carry", 32'(carry), 32'h0);
    check("rst_wrap_bcd", 32'(bcd), 32'h0);
    check("rst_wrap_sv", 32'(snap_valid), 32'h0);
    cyc(1, 1, 0, 0, 0);
    check("post_rst_first", 32'(carry), 32'h0);

    // Randomized upstream: mostly legal steps, some gaps and junk values
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        cyc(0, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
      end else if (r < 9) begin
        g_q = int'($urandom_range(0, 15));
        cyc(1, g_q, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
        g_q = (g_q >= 10 || g_q == 0) ? 1 : g_q + 1;
      end else begin
        nxt(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
    end

    // Overflow: 999 wraps, then the 1000th, then 5 more
    do_reset();
    run(1 + 999 * 10, 1);
    check("bcd_999", 32'(bcd), 32'h999);
    check("ovf_before", 32'(overflow), 32'h0);
    run(10, 1);
    check("bcd_rollover", 32'(bcd), 32'h000);
    check("ovf_set", 32'(overflow), 32'h1);
    run(50, 1);
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("bcd_after_ovf", 32'(bcd), 32'h005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
